// File: rtl/piarb_pio_ntgt_pkg.sv
// Shared PIO arbiter types: data width, data type and the 2-bit FSM encoding.
// Used by piarb_pio_ntgt and, with PIO_TIMEOUT_EN, piarb_pio_tmo.
package piarb_pio_ntgt_pkg;

  localparam int PIO_NBITS = 32;

  typedef logic [PIO_NBITS-1:0] pio_range_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    NOSEL = 2'd2,
    RESP  = 2'd3
  } pio_state_t;

endpackage

// File: rtl/piarb_pio_tmo.sv
// BUSY-phase timeout counter for piarb_pio_ntgt.
// Exists only when PIO_TIMEOUT_EN is defined.
`ifdef PIO_TIMEOUT_EN
module piarb_pio_tmo #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // fires during the TIMEOUT_CYC-th BUSY cycle
  assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/piarb_pio_ntgt.sv
// PIO request router to NUM_TGT memory targets with strobe-aligned response.
// Define PIO_TIMEOUT_EN to add a BUSY timeout (piarb_pio_tmo).
module piarb_pio_ntgt
  import piarb_pio_ntgt_pkg::*;
#(
  parameter int NUM_TGT     = 4,
  parameter int SEL_LSB     = 8,
  parameter int SEL_NBITS   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clk_div,
  input  logic                         reg_bs,
  input  logic                         reg_wr,
  input  logic                         reg_rd,
  input  logic [PIO_NBITS-1:0]         reg_addr,
  input  logic [NUM_TGT-1:0]           tgt_ack,
  input  logic [NUM_TGT*PIO_NBITS-1:0] tgt_rdata,
  output logic [NUM_TGT-1:0]           tgt_ms,
  output logic                         pio_ack,
  output logic                         pio_rvalid,
  output logic [PIO_NBITS-1:0]         pio_rdata,
  output logic                         pio_err
);

  if (NUM_TGT < 1 || NUM_TGT > 16 || NUM_TGT > (1 << SEL_NBITS)) begin : g_bad_ntgt
    $error("piarb_pio_ntgt: NUM_TGT out of range");
  end
  if (SEL_LSB + SEL_NBITS > PIO_NBITS || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("piarb_pio_ntgt: bad select field or TIMEOUT_CYC");
  end

  pio_state_t           state, state_n;
  logic [SEL_NBITS-1:0] idx;
  logic                 is_rd;
  pio_range_t           cap;
  logic                 err;

  logic [SEL_NBITS-1:0] sel;
  logic                 req;
  logic                 sel_ok;
  logic                 ack_sel;
  pio_range_t           rdata_sel;
  logic [NUM_TGT-1:0]   ms_c;
  logic                 unused_ok;

  assign sel       = reg_addr[SEL_LSB +: SEL_NBITS];
  assign req       = reg_rd | reg_wr;
  assign sel_ok    = int'(sel) < NUM_TGT;
  assign unused_ok = ^{reg_bs, reg_addr};

  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    ms_c      = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (idx == SEL_NBITS'(i)) begin
        ack_sel   = tgt_ack[i];
        rdata_sel = tgt_rdata[i*PIO_NBITS +: PIO_NBITS];
        ms_c[i]   = (state == BUSY);
      end
    end
  end

  assign tgt_ms = ms_c;

`ifdef PIO_TIMEOUT_EN
  logic tmo;

  piarb_pio_tmo #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (state != BUSY),
    .en     (state == BUSY),
    .expire (tmo)
  );
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req) state_n = sel_ok ? BUSY : NOSEL;
      end
      BUSY: begin
        if (ack_sel) state_n = RESP;
`ifdef PIO_TIMEOUT_EN
        else if (tmo) state_n = RESP;
`endif
      end
      NOSEL: state_n = RESP;
      RESP: begin
        if (clk_div) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx   <= '0;
      is_rd <= 1'b0;
      cap   <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            idx   <= sel;
            is_rd <= reg_rd;
            cap   <= '0;
            err   <= 1'b0;
          end
        end
        BUSY: begin
          if (ack_sel) begin
            cap <= rdata_sel;
            err <= 1'b0;
          end
`ifdef PIO_TIMEOUT_EN
          else if (tmo) begin
            cap <= '0;
            err <= 1'b1;
          end
`endif
        end
        NOSEL: begin
          cap <= '0;
          err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // host side only moves on the clk_div strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pio_ack    <= 1'b0;
      pio_rvalid <= 1'b0;
      pio_rdata  <= '0;
      pio_err    <= 1'b0;
    end else if (clk_div) begin
      if (state == RESP) begin
        pio_ack    <= 1'b1;
        pio_rvalid <= is_rd;
        pio_rdata  <= is_rd ? cap : '0;
        pio_err    <= err;
      end else begin
        pio_ack    <= 1'b0;
        pio_rvalid <= 1'b0;
        pio_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piarb_pio_ntgt.sv
// Directed-vector bench for piarb_pio_ntgt (NUM_TGT=4, TIMEOUT_CYC=8).
// Timeout sequence runs only when PIO_TIMEOUT_EN is defined.
module tb_piarb_pio_ntgt;

  localparam int NT = 4;
  localparam int NB = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              clk_div;
  logic              reg_bs;
  logic              reg_wr;
  logic              reg_rd;
  logic [NB-1:0]     reg_addr;
  logic [NT-1:0]     tgt_ack;
  logic [NT*NB-1:0]  tgt_rdata;
  logic [NT-1:0]     tgt_ms;
  logic              pio_ack;
  logic              pio_rvalid;
  logic [NB-1:0]     pio_rdata;
  logic              pio_err;

  int checks = 0;
  int errors = 0;
  bit div4   = 1'b0;
  int dcnt   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  sel;
    int          ack_at;
    logic [3:0]  noise;
    logic [31:0] data;
    logic [3:0]  exp_ms;
    int          exp_ms_cyc;
    int          exp_lat;
    logic        exp_rv;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  piarb_pio_ntgt #(
    .NUM_TGT     (NT),
    .SEL_LSB     (8),
    .SEL_NBITS   (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div    (clk_div),
    .reg_bs     (reg_bs),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .tgt_ack    (tgt_ack),
    .tgt_rdata  (tgt_rdata),
    .tgt_ms     (tgt_ms),
    .pio_ack    (pio_ack),
    .pio_rvalid (pio_rvalid),
    .pio_rdata  (pio_rdata),
    .pio_err    (pio_err)
  );

  always #5 clk = ~clk;

  // strobe: tied high, or high one cycle in four
  initial begin
    clk_div = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (div4) begin
        dcnt    = (dcnt + 1) % 4;
        clk_div = (dcnt == 0);
      end else begin
        clk_div = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_junk();
    for (int i = 0; i < NT; i++)
      tgt_rdata[i*NB +: NB] = 32'hBAD0_0000 | 32'(i);
  endtask

  task automatic run(input vec_t v, input int n);
    int ms_cnt  = 0;
    int ms_bad  = 0;
    int ack_cnt = 0;
    int first   = 0;
    logic        rv = 1'b0;
    logic [31:0] rd = '0;
    logic        er = 1'b0;
    reg_addr = {16'h00F0, v.sel, 8'h3C};
    reg_rd   = v.rd;
    reg_wr   = v.wr;
    @(posedge clk);
    #1;
    reg_rd = 1'b0;
    reg_wr = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      set_junk();
      tgt_ack = v.noise;
      if (c == v.ack_at) begin
        tgt_ack[v.sel[1:0]] = 1'b1;
        tgt_rdata[32'(v.sel[1:0])*NB +: NB] = v.data;
      end
      @(negedge clk);
      if (tgt_ms != 0) begin
        ms_cnt++;
        if (tgt_ms != v.exp_ms) ms_bad++;
      end
      if (pio_ack) begin
        ack_cnt++;
        if (first == 0) begin
          first = c;
          rv = pio_rvalid;
          rd = pio_rdata;
          er = pio_err;
        end
      end
      @(posedge clk);
      #1;
    end
    tgt_ack = '0;
    chk($sformatf("v%0d ms_cycles", n), 32'(ms_cnt), 32'(v.exp_ms_cyc));
    chk($sformatf("v%0d ms_value", n), 32'(ms_bad), 32'd0);
    chk($sformatf("v%0d ack_count", n), 32'(ack_cnt), 32'd1);
    chk($sformatf("v%0d latency", n), 32'(first), 32'(v.exp_lat));
    chk($sformatf("v%0d rvalid", n), 32'(rv), 32'(v.exp_rv));
    chk($sformatf("v%0d rdata", n), rd, v.exp_rdata);
    chk($sformatf("v%0d err", n), 32'(er), 32'(v.exp_err));
  endtask

  initial begin
    vec_t v;
    int ack_cnt, misalign;
    logic prev_ack, prev_div;
    logic [31:0] rd_seen;

    vecs[0] = '{1, 0, 4'd2,  3, 4'h0, 32'hA5A5_0002, 4'b0100, 3, 5, 1, 32'hA5A5_0002, 0};
    vecs[1] = '{0, 1, 4'd9,  1, 4'h0, 32'h1111_1111, 4'b0000, 0, 3, 0, 32'h0, 1};
    vecs[2] = '{1, 0, 4'd0,  1, 4'h0, 32'h1234_5678, 4'b0001, 1, 3, 1, 32'h1234_5678, 0};
    vecs[3] = '{1, 1, 4'd3,  2, 4'h0, 32'hDEAD_BEEF, 4'b1000, 2, 4, 1, 32'hDEAD_BEEF, 0};
    vecs[4] = '{0, 1, 4'd1,  1, 4'h0, 32'hFFFF_0000, 4'b0010, 1, 3, 0, 32'h0, 0};
    vecs[5] = '{1, 0, 4'd1,  4, 4'hD, 32'hC0DE_0001, 4'b0010, 4, 6, 1, 32'hC0DE_0001, 0};
    vecs[6] = '{1, 0, 4'd4,  1, 4'h0, 32'h2222_2222, 4'b0000, 0, 3, 1, 32'h0, 1};
    vecs[7] = '{1, 0, 4'd15, 1, 4'h0, 32'h3333_3333, 4'b0000, 0, 3, 1, 32'h0, 1};

    rstn     = 1'b0;
    reg_bs   = 1'b1;
    reg_wr   = 1'b0;
    reg_rd   = 1'b0;
    reg_addr = '0;
    tgt_ack  = '0;
    set_junk();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tgt_ms", 32'(tgt_ms), 32'd0);
    chk("rst pio_ack", 32'(pio_ack), 32'd0);
    chk("rst pio_rvalid", 32'(pio_rvalid), 32'd0);
    chk("rst pio_rdata", pio_rdata, 32'd0);
    chk("rst pio_err", 32'(pio_err), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run(vecs[i], i);

    // strobe every 4th cycle: ack spans one strobe period
    div4 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reg_addr = {16'h0, 4'd0, 8'h00};
    reg_rd   = 1'b1;
    @(posedge clk);
    #1;
    reg_rd = 1'b0;
    tgt_ack = 4'b0001;
    tgt_rdata[0 +: NB] = 32'h0BAD_F00D;
    ack_cnt  = 0;
    misalign = 0;
    rd_seen  = '0;
    prev_ack = 1'b0;
    prev_div = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (pio_ack !== prev_ack && !prev_div) misalign++;
      if (pio_ack) begin
        ack_cnt++;
        rd_seen = pio_rdata;
      end
      prev_ack = pio_ack;
      prev_div = clk_div;
      @(posedge clk);
      #1;
      tgt_ack = '0;
    end
    chk("div4 ack_len", 32'(ack_cnt), 32'd4);
    chk("div4 align", 32'(misalign), 32'd0);
    chk("div4 rdata", rd_seen, 32'h0BAD_F00D);
    div4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // second request while BUSY, then reset mid-transaction
    reg_addr = {16'h0, 4'd1, 8'h00};
    reg_rd   = 1'b1;
    @(posedge clk);
    #1;
    reg_addr = {16'h0, 4'd2, 8'h00};
    @(negedge clk);
    chk("busy2 ms_a", 32'(tgt_ms), 32'b0010);
    @(posedge clk);
    #1;
    reg_rd = 1'b0;
    @(negedge clk);
    chk("busy2 ms_b", 32'(tgt_ms), 32'b0010);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst ms", 32'(tgt_ms), 32'd0);
    chk("midrst ack", 32'(pio_ack), 32'd0);
    @(posedge clk);
    #1;
    rstn    = 1'b1;
    tgt_ack = 4'b0110;
    ack_cnt  = 0;
    misalign = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pio_ack) ack_cnt++;
      if (tgt_ms != 0) misalign++;
      @(posedge clk);
      #1;
    end
    tgt_ack = '0;
    chk("postrst ack", 32'(ack_cnt), 32'd0);
    chk("postrst ms", 32'(misalign), 32'd0);
    v = '{1, 0, 4'd3, 1, 4'h0, 32'h5555_AAAA, 4'b1000, 1, 3, 1, 32'h5555_AAAA, 0};
    run(v, 8);

`ifdef PIO_TIMEOUT_EN
    v = '{1, 0, 4'd2, 12, 4'h0, 32'h4444_4444, 4'b0100, 8, 10, 1, 32'h0, 1};
    run(v, 9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piarb_pio_ntgt.md
PIARB_PIO_NTGT -- requirements
Module: piarb_pio_ntgt

Interface
REQ-001 SHALL have parameter NUM_TGT, default 4, number of memory targets (1..16).
REQ-002 SHALL have parameter SEL_LSB, default 8, lowest reg_addr bit of the target-select field.
REQ-003 SHALL have parameter SEL_NBITS, default 4, width of the target-select field.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, BUSY cycles before timeout (only used with PIO_TIMEOUT_EN).
REQ-005 SHALL have ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous, active-low reset.
- clk_div  in  1  PIO strobe; host-facing outputs update only when high.
- reg_bs  in  1  bus select, informational.
- reg_wr  in  1  write request pulse.
- reg_rd  in  1  read request pulse.
- reg_addr  in  PIO_NBITS  register address.
- tgt_ack  in  NUM_TGT  per-target ack.
- tgt_rdata  in  NUM_TGT*PIO_NBITS  per-target read data, target i at slice i.
- tgt_ms  out  NUM_TGT  one-hot target select.
- pio_ack  out  1  transaction ack.
- pio_rvalid  out  1  read data valid.
- pio_rdata  out  PIO_NBITS  read data.
- pio_err  out  1  no-target or timeout.

Function
REQ-006 SHALL implement FSM states IDLE, BUSY, NOSEL, RESP.
REQ-007 IDLE: on reg_rd|reg_wr, SHALL capture idx = reg_addr[SEL_LSB +: SEL_NBITS] and is_rd = reg_rd; SHALL go to BUSY if idx < NUM_TGT, else NOSEL.
REQ-008 SHALL give reg_rd precedence when reg_rd and reg_wr are both high (is_rd=1).
REQ-009 SHALL ignore reg_rd/reg_wr in any state other than IDLE.
REQ-010 BUSY: tgt_ms SHALL be one-hot at the captured idx; in every other state tgt_ms SHALL be 0.
- tgt_ack of non-selected targets SHALL be ignored.
REQ-011 BUSY: on tgt_ack[idx]=1, SHALL capture tgt_rdata slice idx with err=0 and go to RESP in the next cycle.
REQ-012 NOSEL: SHALL go to RESP in the next cycle with captured data=0 and err=1.
REQ-013 RESP: on the first cycle with clk_div=1, SHALL register pio_ack=1, pio_rvalid=is_rd, pio_rdata=captured data (0 when is_rd=0), pio_err=err, and return to IDLE.
REQ-014 On every other clk_div=1 cycle, pio_ack, pio_rvalid and pio_err SHALL register 0; pio_rdata SHALL hold its value.
REQ-015 On cycles with clk_div=0, all four host outputs SHALL hold; each ack therefore lasts one clk_div period.
REQ-016 Latency: request to pio_ack SHALL be ack-wait + 1 cycle + wait for the next clk_div strobe; with clk_div tied high, a target acking in its first BUSY cycle gives pio_ack 3 cycles after the request.

Reset
REQ-017 Reset SHALL force state=IDLE and zero the outputs pio_ack, pio_rvalid, pio_rdata, pio_err and tgt_ms.
REQ-018 Reset SHALL also zero the internal registers idx, is_rd, captured data, err and the timeout counter.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no ack; a tgt_ack arriving after reset SHALL be ignored.

Configuration
REQ-020 With PIO_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle.
- When it reaches TIMEOUT_CYC without tgt_ack[idx], SHALL go to RESP with data=0 and err=1.
- If tgt_ack[idx] arrives in the same cycle as expiry, the ack SHALL win.
REQ-021 Without PIO_TIMEOUT_EN, BUSY SHALL wait indefinitely and SHALL contain no counter logic.

Structure
REQ-022 PIO_NBITS/PIO_RANGE and the FSM state encoding (2 bits) SHALL come from the shared defines/package.
REQ-023 The module SHALL be single-level; the timeout counter MAY be the sub-module piarb_pio_tmo.

Verification
REQ-024 Read, target 2, tgt_ack[2] on the 3rd BUSY cycle, rdata=0xA5A5_0002, clk_div tied high -> tgt_ms=4'b0100 for 3 cycles; pio_ack=1, pio_rvalid=1, pio_rdata=0xA5A5_0002, pio_err=0 for exactly 1 cycle.
REQ-025 Write to idx=9 with NUM_TGT=4 -> tgt_ms stays 0; at the next strobe pio_ack=1, pio_rvalid=0, pio_err=1.
REQ-026 clk_div high every 4th cycle, target 0 ack -> pio_ack high for exactly 4 cycles, aligned to strobes.
REQ-027 PIO_TIMEOUT_EN, TIMEOUT_CYC=8, no ack -> pio_ack with pio_err=1, pio_rdata=0 after 8 BUSY cycles; a late tgt_ack is ignored.
REQ-028 Second reg_rd while BUSY, then rstn low during BUSY -> second request dropped; after reset, no pio_ack and state=IDLE.
